alu_flags: RTL and testbench
============================

ALU_FLAGS -- requirements
Module: alu_flags

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width of the A/B registers, the ALU result and the bus.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: bus_in  input  WIDTH  current value of the shared CPU bus.
REQ-005 Port: ai  input  1  control-unit strobe; load A from bus_in.
REQ-006 Port: ao  input  1  control-unit strobe; drive A onto the bus.
REQ-007 Port: bi  input  1  control-unit strobe; load B from bus_in.
REQ-008 Port: eo  input  1  control-unit strobe; drive the ALU result onto the bus.
REQ-009 Port: su  input  1  ALU mode; 0 = add, 1 = subtract.
REQ-010 Port: fi  input  1  control-unit strobe; capture the carry and zero flags.
REQ-011 Port: bus_out  output  WIDTH  value this block drives toward the bus.
REQ-012 Port: bus_oe  output  1  high when bus_out is valid for the bus multiplexer.
REQ-013 Port: flag_c  output  1  registered carry flag; feeds the control unit's carry-flag input.
REQ-014 Port: flag_z  output  1  registered zero flag; feeds the control unit's zero-flag input.
REQ-015 Port: a_q  output  WIDTH  A register contents, for debug.
REQ-016 Port: b_q  output  WIDTH  B register contents, for debug.
REQ-017 Port: bus_err  output  1  sticky flag set on a bus-drive conflict.

Function
REQ-018 A shall load bus_in on a rising clk edge when ai=1, and shall hold otherwise.
REQ-019 B shall load bus_in on a rising clk edge when bi=1, and shall hold otherwise.
REQ-020 The ALU shall be combinational from the current A, B and su; it adds no cycles of latency.
REQ-021 Add mode (su=0): {cout, res} = A + B, computed at WIDTH+1 bits.
REQ-022 Subtract mode (su=1): {cout, res} = A + ~B + 1; cout=1 means no borrow (A >= B unsigned).
REQ-023 res shall wrap modulo 2^WIDTH; overflow is reported only through cout.
REQ-024 On a rising clk edge with fi=1, flag_c <= cout and flag_z <= (res == 0), both taken from the pre-edge A, B and su.
REQ-025 With fi=0, flag_c and flag_z shall hold their values.
REQ-026 If ai or bi is asserted on the same edge as fi, the flags shall use the old register values; the new values affect res from the next cycle onward.
REQ-027 Bus output is combinational:
- ao=1, eo=0: bus_out = A, bus_oe = 1.
- eo=1, ao=0: bus_out = res, bus_oe = 1.
- neither asserted: bus_out = 0, bus_oe = 0.
REQ-028 Conflict (ao=1 and eo=1): bus_out = 0, bus_oe = 1, and bus_err shall be set at the next rising clk edge.
REQ-029 Once set, bus_err shall stay set until reset.
REQ-030 If ai and ao are both asserted, bus_out shall show the pre-edge A, and A shall capture bus_in at the edge.
REQ-031 The block shall not prevent the shared bus from taking the value it drives; the outputs shall behave exactly as in REQ-027 to REQ-030 in that case.

Reset
REQ-032 While rst_n=0, regardless of clk, all registered state shall be cleared: A=0, B=0, flag_c=0, flag_z=0, bus_err=0.
REQ-033 During reset, bus_out and bus_oe shall follow REQ-027 from the cleared A and B.
REQ-034 A reset asserted mid-operation shall discard any load or flag capture in progress on that cycle.
REQ-035 The first load shall occur on the first rising edge after rst_n returns high.

Verification
REQ-036 Reset check: rst_n low with ai=1, bus_in=0xAA -> a_q=0x00, flag_c=0, flag_z=0, bus_err=0, bus_oe=0.
REQ-037 Add: A<=0x05, B<=0x03, then eo=1, su=0, fi=1 -> bus_out=0x08, bus_oe=1; after the edge flag_c=0, flag_z=0.
REQ-038 Add wrap: A=0xFF, B=0x01, su=0, fi=1 -> res=0x00; after the edge flag_c=1, flag_z=1.
REQ-039 Subtract, A < B: A=0x03, B=0x05, su=1 -> res=0xFE; after fi flag_c=0, flag_z=0.
REQ-040 Subtract, A = B: A=0x05, B=0x05, su=1, fi=1 -> flag_c=1, flag_z=1.
REQ-041 Load/flag ordering: A=0x00, B=0x00, ai=1 with bus_in=0x07 and fi=1 on the same edge -> flag_z=1 (old A), and a_q=0x07 after the edge.
REQ-042 Conflict: ao=1 and eo=1 for one cycle -> bus_out=0x00, bus_oe=1; bus_err=1 after the edge; bus_err stays 1 across 10 idle cycles; a reset pulse clears it.

Source files
------------

// File: rtl/alu_flags.sv
// Accumulator-style ALU slice: A/B registers, add/subtract datapath,
// carry/zero flag capture and a bus driver with sticky conflict detection.
module alu_flags #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             ai,
    input  logic             ao,
    input  logic             bi,
    input  logic             eo,
    input  logic             su,
    input  logic             fi,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             flag_c,
    output logic             flag_z,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic             bus_err
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] res;
    logic             cout;

    // Subtract as A + ~B + 1 so cout doubles as the no-borrow indicator
    always_comb begin
        b_op = su ? ~b_q : b_q;
        sum  = SUM_W'(a_q) + SUM_W'(b_op) + SUM_W'(su);
        res  = sum[WIDTH-1:0];
        cout = sum[WIDTH];
    end

    // Operand registers; loads and flag capture all see pre-edge A/B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (ai) a_q <= bus_in;
            if (bi) b_q <= bus_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (fi) begin
                flag_c <= cout;
                flag_z <= (res == '0);
            end
            if (ao && eo) bus_err <= 1'b1;
        end
    end

    // Conflicting drive requests still claim the bus but put zero on it
    always_comb begin
        bus_out = '0;
        bus_oe  = 1'b0;
        if (ao && eo) begin
            bus_oe = 1'b1;
        end else if (ao) begin
            bus_out = a_q;
            bus_oe  = 1'b1;
        end else if (eo) begin
            bus_out = res;
            bus_oe  = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_flags.sv
// Directed plus randomized bench for alu_flags against an arithmetic reference model.
module tb_alu_flags;

    localparam int unsigned W = 8;
    localparam int M = 256;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] bus_in;
    logic         ai, ao, bi, eo, su, fi;
    logic [W-1:0] bus_out;
    logic         bus_oe;
    logic         flag_c, flag_z;
    logic [W-1:0] a_q, b_q;
    logic         bus_err;

    int checks = 0;
    int errors = 0;

    int   a_m, b_m;
    logic fc_m, fz_m, err_m;
    logic [W-1:0] obs_bus;
    logic         obs_oe;

    alu_flags #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in),
        .ai(ai), .ao(ao), .bi(bi), .eo(eo), .su(su), .fi(fi),
        .bus_out(bus_out), .bus_oe(bus_oe),
        .flag_c(flag_c), .flag_z(flag_z),
        .a_q(a_q), .b_q(b_q), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Unsigned add/subtract on plain integers, wrapped to W bits
    function automatic void ref_alu(input int a, input int b, input logic s,
                                    output int r, output logic c);
        if (!s) begin
            r = (a + b) % M;
            c = (a + b) >= M;
        end else begin
            r = (a - b + M) % M;
            c = (a >= b);
        end
    endfunction

    task automatic check_regs();
        chk("a_q", 32'(a_q), 32'(a_m));
        chk("b_q", 32'(b_q), 32'(b_m));
        chk("flag_c", 32'(flag_c), 32'(fc_m));
        chk("flag_z", 32'(flag_z), 32'(fz_m));
        chk("bus_err", 32'(bus_err), 32'(err_m));
    endtask

    task automatic step(input logic i_ai, input logic i_ao, input logic i_bi,
                        input logic i_eo, input logic i_su, input logic i_fi,
                        input logic [W-1:0] i_bus);
        int   r;
        logic c;
        int   exp_bus;
        logic exp_oe;
        ai = i_ai; ao = i_ao; bi = i_bi; eo = i_eo; su = i_su; fi = i_fi; bus_in = i_bus;
        #1;
        ref_alu(a_m, b_m, i_su, r, c);
        if (i_ao && i_eo) begin exp_bus = 0;   exp_oe = 1'b1; end
        else if (i_ao)    begin exp_bus = a_m; exp_oe = 1'b1; end
        else if (i_eo)    begin exp_bus = r;   exp_oe = 1'b1; end
        else              begin exp_bus = 0;   exp_oe = 1'b0; end
        obs_bus = bus_out;
        obs_oe  = bus_oe;
        chk("bus_out", 32'(bus_out), 32'(exp_bus));
        chk("bus_oe", 32'(bus_oe), 32'(exp_oe));
        @(posedge clk);
        if (i_fi) begin
            fc_m = c;
            fz_m = (r == 0);
        end
        if (i_ai) a_m = int'(i_bus);
        if (i_bi) b_m = int'(i_bus);
        if (i_ao && i_eo) err_m = 1'b1;
        #1;
        check_regs();
    endtask

    task automatic clear_model();
        a_m = 0; b_m = 0; fc_m = 1'b0; fz_m = 1'b0; err_m = 1'b0;
    endtask

    // Reset in mid-cycle with loads and flag capture pending; all must be discarded
    task automatic pulse_reset();
        ai = 1'b1; bi = 1'b1; fi = 1'b1; ao = 1'b0; eo = 1'b0; su = 1'b0; bus_in = 8'h5A;
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        rst_n = 1'b1;
        ai = 1'b0; bi = 1'b0; fi = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ai = 1'b1; ao = 1'b0; bi = 1'b0; eo = 1'b0; su = 1'b0; fi = 1'b1; bus_in = 8'hAA;
        clear_model();
        #1;
        chk("rst_oe_idle", 32'(bus_oe), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_q", 32'(a_q), 32'h00);
        chk("rst_flag_c", 32'(flag_c), 32'h0);
        chk("rst_flag_z", 32'(flag_z), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_bus_oe", 32'(bus_oe), 32'h0);
        ao = 1'b1;
        #1;
        chk("rst_ao_bus", 32'(bus_out), 32'h00);
        chk("rst_ao_oe", 32'(bus_oe), 32'h1);
        ao = 1'b0;
        rst_n = 1'b1;
        ai = 1'b0; fi = 1'b0;

        // Add
        step(1, 0, 0, 0, 0, 0, 8'h05);
        chk("first_load_a", 32'(a_q), 32'h05);
        step(0, 0, 1, 0, 0, 0, 8'h03);
        step(0, 0, 0, 1, 0, 1, 8'h00);
        chk("add_bus", 32'(obs_bus), 32'h08);
        chk("add_oe", 32'(obs_oe), 32'h1);
        chk("add_c", 32'(flag_c), 32'h0);
        chk("add_z", 32'(flag_z), 32'h0);

        // Add wrap
        step(1, 0, 0, 0, 0, 0, 8'hFF);
        step(0, 0, 1, 0, 0, 0, 8'h01);
        step(0, 0, 0, 1, 0, 1, 8'h00);
        chk("wrap_bus", 32'(obs_bus), 32'h00);
        chk("wrap_c", 32'(flag_c), 32'h1);
        chk("wrap_z", 32'(flag_z), 32'h1);

        // Subtract A < B
        step(1, 0, 0, 0, 0, 0, 8'h03);
        step(0, 0, 1, 0, 0, 0, 8'h05);
        step(0, 0, 0, 1, 1, 1, 8'h00);
        chk("sub_lt_bus", 32'(obs_bus), 32'hFE);
        chk("sub_lt_c", 32'(flag_c), 32'h0);
        chk("sub_lt_z", 32'(flag_z), 32'h0);

        // Subtract A == B
        step(1, 0, 1, 0, 0, 0, 8'h05);
        step(0, 0, 0, 0, 1, 1, 8'h00);
        chk("sub_eq_c", 32'(flag_c), 32'h1);
        chk("sub_eq_z", 32'(flag_z), 32'h1);

        // Load/flag ordering: first clear flags using old 5+5, then load A with old A=0
        step(1, 0, 1, 0, 0, 1, 8'h00);
        chk("ord_pre_z", 32'(flag_z), 32'h0);
        step(1, 0, 0, 0, 0, 1, 8'h07);
        chk("ord_z", 32'(flag_z), 32'h1);
        chk("ord_a_q", 32'(a_q), 32'h07);

        // Simultaneous load and drive of A
        step(1, 1, 0, 0, 0, 0, 8'h33);
        chk("ai_ao_bus", 32'(obs_bus), 32'h07);
        chk("ai_ao_a_q", 32'(a_q), 32'h33);

        // Conflict and sticky error
        step(0, 1, 0, 1, 0, 0, 8'h00);
        chk("conf_bus", 32'(obs_bus), 32'h00);
        chk("conf_oe", 32'(obs_oe), 32'h1);
        chk("conf_err", 32'(bus_err), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0, 8'h00);
            chk("conf_sticky", 32'(bus_err), 32'h1);
        end
        pulse_reset();
        chk("conf_cleared", 32'(bus_err), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic r_ai, r_ao, r_bi, r_eo, r_su, r_fi;
            logic [W-1:0] r_bus;
            r_ai = 1'($urandom_range(0, 1));
            r_bi = 1'($urandom_range(0, 1));
            r_ao = 1'($urandom_range(0, 1));
            r_eo = 1'($urandom_range(0, 1));
            r_su = 1'($urandom_range(0, 1));
            r_fi = 1'($urandom_range(0, 1));
            if (r_ao && r_eo && ($urandom_range(0, 15) != 0)) r_eo = 1'b0;
            case ($urandom_range(0, 7))
                0:       r_bus = 8'h00;
                1:       r_bus = 8'hFF;
                2:       r_bus = 8'(a_m);
                default: r_bus = 8'($urandom);
            endcase
            step(r_ai, r_ao, r_bi, r_eo, r_su, r_fi, r_bus);
            if (i == 150) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
